// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] HALT_INSTR = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_sync_fifo.sv
// Synchronous FIFO with occupancy count; head word is visible combinationally.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Storage array: written on push, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  a_no_push_when_full : assert property (@(posedge clk) disable iff (rst) !(push && full))
    else $error("sync_fifo: push into full FIFO");

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: loadable instruction memory, program counter and a prefetch
// FIFO presenting one instruction per cycle over a valid/ready handshake.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
  input  logic [31:0]                   load_data,
  input  logic                          start,
  input  logic                          instr_ready,
  output logic [31:0]                   instruction,
  output logic                          instr_valid,
  output logic [31:0]                   pc_out,
  output logic                          done
);

  localparam int unsigned AW         = $clog2(IMEM_DEPTH);
  localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] PC_END     = 32'(IMEM_DEPTH * 4);
  localparam logic [CW:0] CREDIT_LIM = (CW + 1)'(FIFO_DEPTH);

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   rd_pc;
  logic [31:0]   rd_data;
  logic          inflight;
  logic [31:0]   imem [IMEM_DEPTH];

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic [31:0]   fifo_head;

  logic          load_ok;
  logic          halt_seen;
  logic          issue;
  logic [CW:0]   used;

  assign load_ok   = (state == IDLE) && load_en;
  assign halt_seen = (state == FETCH) && inflight && (rd_data == HALT_INSTR);
  assign used      = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  // A read that would coincide with a returning halt word is simply never
  // issued; this is indistinguishable from issuing and discarding it.
  assign issue     = (state == FETCH) && !halt_seen && (used < CREDIT_LIM) && (pc < PC_END);
  assign fifo_push = (state == FETCH) && inflight && (rd_data != HALT_INSTR);
  assign fifo_pop  = instr_valid && instr_ready;

  assign instr_valid = !fifo_empty;
  assign instruction = instr_valid ? fifo_head : NOP_INSTR;
  assign pc_out      = pc;

  // Instruction memory: load port in IDLE, synchronous read port in FETCH.
  always_ff @(posedge clk) begin
    if (load_ok) imem[load_addr] <= load_data;
    if (issue)   rd_data <= imem[pc[2 +: AW]];
  end

  // Fetch control FSM with registered pc, read tracking and done flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      rd_pc    <= '0;
      inflight <= 1'b0;
      done     <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        rd_pc <= pc;
        pc    <= pc + 32'd4;
      end
      case (state)
        IDLE: begin
          if (!load_en && start) begin
            state <= FETCH;
            pc    <= RESET_PC;
          end
        end
        FETCH: begin
          if (halt_seen) begin
            pc    <= rd_pc;
            state <= DRAIN;
          end else if ((pc == PC_END) && !inflight) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (rd_data),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  a_credit_ok : assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full))
    else $error("instr_fetch: prefetch credit overrun");

  a_pc_aligned : assert property (@(posedge clk) RESET_PC[1:0] == 2'b00)
    else $error("instr_fetch: RESET_PC not word aligned");

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for the instruction fetch stage.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [5:0]  load_addr;
  logic [31:0] load_data;
  logic        start;
  logic        instr_ready;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic        done;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] prog [64];

  instr_fetch #(
    .IMEM_DEPTH(64),
    .FIFO_DEPTH(4),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc_out      (pc_out),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; load_en = 1'b0; start = 1'b0; instr_ready = 1'b0;
    load_addr = '0; load_data = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_word(input int a, input logic [31:0] d);
    load_en = 1'b1; load_addr = 6'(a); load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  // Loads prog[0..n-1] followed by a halt word when room remains.
  task automatic load_prog(input int n);
    for (int i = 0; i < n; i++) load_word(i, prog[i]);
    if (n < 64) load_word(n, 32'h0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    n_checks++; if (instruction !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", instruction, NOP); end
    n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", pc_out); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    apply_reset();
    prog[0] = 32'h00500093; prog[1] = 32'h00A0E113; prog[2] = 32'h0FF17193;
    load_prog(3);
    pulse_start();
    tick(); tick(); tick();
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL midrun_valid: got %b expected 1", instr_valid); end
    rst = 1'b1;
    #1;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid: got %b expected 0", instr_valid); end
    n_checks++; if (instruction !== NOP) begin n_fail++; $display("FAIL async_reset_instr: got %h expected %h", instruction, NOP); end
    n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL async_reset_pc: got %h expected 0", pc_out); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL async_reset_done: got %b expected 0", done); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int got;
    apply_reset();
    prog[0] = 32'h00500093; prog[1] = 32'h00A0E113; prog[2] = 32'h0FF17193;
    load_prog(3);
    instr_ready = 1'b1;
    pulse_start();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat0: got valid %b expected 0", instr_valid); end
    tick();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat1: got valid %b expected 0", instr_valid); end
    tick();
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_lat2: got valid %b expected 1", instr_valid); end
    got = 0;
    for (int c = 0; c < 50 && done !== 1'b1; c++) begin
      if (instr_valid === 1'b1) begin
        n_checks++;
        if (got >= 3 || instruction !== prog[got]) begin n_fail++; $display("FAIL basic_word[%0d]: got %h expected %h", got, instruction, (got < 3) ? prog[got] : NOP); end
        got++;
      end else begin
        n_checks++; if (instruction !== NOP) begin n_fail++; $display("FAIL basic_nop: got %h expected %h", instruction, NOP); end
      end
      tick();
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b expected 1", done); end
    n_checks++; if (got != 3) begin n_fail++; $display("FAIL basic_count: got %0d expected 3", got); end
    n_checks++; if (pc_out !== 32'd12) begin n_fail++; $display("FAIL basic_pc: got %0d expected 12", pc_out); end
  endtask

  task automatic test_backpressure();
    int got;
    apply_reset();
    for (int i = 0; i < 8; i++) prog[i] = 32'h00500093 + 32'(i) * 32'h0010_0000;
    load_prog(8);
    instr_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (pc_out !== 32'd16) begin n_fail++; $display("FAIL bp_pc_stall: got %0d expected 16", pc_out); end
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", instr_valid); end
    n_checks++; if (instruction !== 32'h00500093) begin n_fail++; $display("FAIL bp_head: got %h expected 00500093", instruction); end
    tick(); tick(); tick();
    n_checks++; if (instruction !== 32'h00500093) begin n_fail++; $display("FAIL bp_hold: got %h expected 00500093", instruction); end
    n_checks++; if (pc_out !== 32'd16) begin n_fail++; $display("FAIL bp_pc_hold: got %0d expected 16", pc_out); end
    got = 0;
    for (int c = 0; c < 80 && done !== 1'b1; c++) begin
      instr_ready = 1'b1;
      if (instr_valid === 1'b1) begin
        n_checks++;
        if (got >= 8 || instruction !== prog[got]) begin n_fail++; $display("FAIL bp_word[%0d]: got %h expected %h", got, instruction, (got < 8) ? prog[got] : NOP); end
        got++;
      end else begin
        n_checks++; if (instruction !== NOP) begin n_fail++; $display("FAIL bp_nop: got %h expected %h", instruction, NOP); end
      end
      tick();
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b expected 1", done); end
    n_checks++; if (got != 8) begin n_fail++; $display("FAIL bp_count: got %0d expected 8", got); end
    n_checks++; if (pc_out !== 32'd32) begin n_fail++; $display("FAIL bp_pc: got %0d expected 32", pc_out); end
  endtask

  task automatic test_full_mem();
    int got;
    apply_reset();
    for (int i = 0; i < 64; i++) prog[i] = 32'h1000_0013 + 32'(i);
    load_prog(64);
    instr_ready = 1'b1;
    pulse_start();
    got = 0;
    for (int c = 0; c < 300 && done !== 1'b1; c++) begin
      if (instr_valid === 1'b1) begin
        n_checks++;
        if (got >= 64 || instruction !== prog[got]) begin n_fail++; $display("FAIL full_word[%0d]: got %h expected %h", got, instruction, (got < 64) ? prog[got] : NOP); end
        got++;
      end
      tick();
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL full_done: got %b expected 1", done); end
    n_checks++; if (got != 64) begin n_fail++; $display("FAIL full_count: got %0d expected 64", got); end
    n_checks++; if (pc_out !== 32'd256) begin n_fail++; $display("FAIL full_pc: got %0d expected 256", pc_out); end
  endtask

  task automatic test_random_ready();
    int          got;
    logic        held;
    logic [31:0] held_val;
    apply_reset();
    for (int i = 0; i < 20; i++) prog[i] = 32'h2000_0093 + (32'(i) << 12);
    load_prog(20);
    instr_ready = 1'b0;
    pulse_start();
    got = 0; held = 1'b0; held_val = '0;
    for (int c = 0; c < 300 && done !== 1'b1; c++) begin
      instr_ready = 1'($urandom_range(0, 1));
      if (held) begin
        n_checks++; if (instr_valid !== 1'b1 || instruction !== held_val) begin n_fail++; $display("FAIL rnd_stable: got %h expected %h", instruction, held_val); end
      end
      if (instr_valid === 1'b1) begin
        if (instr_ready) begin
          n_checks++;
          if (got >= 20 || instruction !== prog[got]) begin n_fail++; $display("FAIL rnd_word[%0d]: got %h expected %h", got, instruction, (got < 20) ? prog[got] : NOP); end
          got++;
        end
      end else begin
        n_checks++; if (instruction !== NOP) begin n_fail++; $display("FAIL rnd_nop: got %h expected %h", instruction, NOP); end
      end
      held = (instr_valid === 1'b1) && !instr_ready;
      held_val = instruction;
      tick();
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rnd_done: got %b expected 1", done); end
    n_checks++; if (got != 20) begin n_fail++; $display("FAIL rnd_count: got %0d expected 20", got); end
    n_checks++; if (pc_out !== 32'd80) begin n_fail++; $display("FAIL rnd_pc: got %0d expected 80", pc_out); end
  endtask

  task automatic test_ignored_inputs();
    int got;
    apply_reset();
    for (int i = 0; i < 4; i++) prog[i] = 32'h00A0_0093 + (32'(i) << 20);
    load_prog(4);
    instr_ready = 1'b0;
    pulse_start();
    tick(); tick();
    load_en = 1'b1; load_addr = 6'd1; load_data = 32'hDEAD_BEEF; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    got = 0;
    for (int c = 0; c < 60 && done !== 1'b1; c++) begin
      instr_ready = 1'b1;
      if (instr_valid === 1'b1) begin
        n_checks++;
        if (got >= 4 || instruction !== prog[got]) begin n_fail++; $display("FAIL ign_word[%0d]: got %h expected %h", got, instruction, (got < 4) ? prog[got] : NOP); end
        got++;
      end
      tick();
    end
    n_checks++; if (got != 4) begin n_fail++; $display("FAIL ign_count: got %0d expected 4", got); end
    load_en = 1'b1; load_addr = 6'd0; load_data = 32'hCAFE_F00D; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ign_done_hold: got %b expected 1", done); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL ign_valid: got %b expected 0", instr_valid); end
    n_checks++; if (instruction !== NOP) begin n_fail++; $display("FAIL ign_instr: got %h expected %h", instruction, NOP); end
    n_checks++; if (pc_out !== 32'd16) begin n_fail++; $display("FAIL ign_pc: got %0d expected 16", pc_out); end
  endtask

  task automatic test_restart();
    int got;
    apply_reset();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rs_done_clear: got %b expected 0", done); end
    n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL rs_pc_clear: got %h expected 0", pc_out); end
    instr_ready = 1'b1;
    pulse_start();
    got = 0;
    for (int c = 0; c < 60 && done !== 1'b1; c++) begin
      if (instr_valid === 1'b1) begin
        n_checks++;
        if (got >= 4 || instruction !== prog[got]) begin n_fail++; $display("FAIL rs_word[%0d]: got %h expected %h", got, instruction, (got < 4) ? prog[got] : NOP); end
        got++;
      end
      tick();
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rs_done: got %b expected 1", done); end
    n_checks++; if (got != 4) begin n_fail++; $display("FAIL rs_count: got %0d expected 4", got); end
    n_checks++; if (pc_out !== 32'd16) begin n_fail++; $display("FAIL rs_pc: got %0d expected 16", pc_out); end
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; start = 1'b0; instr_ready = 1'b0;
    load_addr = '0; load_data = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_full_mem();
    test_random_ready();
    test_ignored_inputs();
    test_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
